// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//
// Measures an active-low PWM input in units of "ticks" (cycles where equal=1).
// For each complete period (falling edge to falling edge) the block reports
// the length of the low (on) phase and of the whole period. If no edge arrives
// for TIMEOUT ticks while measuring, the input is declared idle and its level
// is reported.
//
// Ports
//   mclk          system clock, all logic on the rising edge
//   rst           synchronous, active-high reset
//   equal         tick enable; counters advance only when high
//   pwm_in        asynchronous PWM input, 0 = on phase
//   on_count      ticks in the last complete low phase
//   period_count  ticks in the last complete period
//   valid         one-cycle pulse when on_count/period_count update
//   timeout       one-cycle pulse when the idle limit expires
//   idle_level    synchronized input level captured at the last timeout
//   overflow      sticky; a measurement counter saturated
// -----------------------------------------------------------------------------
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             equal,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] on_count,
  output logic [CNT_W-1:0] period_count,
  output logic             valid,
  output logic             timeout,
  output logic             idle_level,
  output logic             overflow
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  // The idle counter expires on the tick that would take it to TIMEOUT.
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge detection
  // ---------------------------------------------------------------------------
  logic sync1_q;
  logic s_q;
  logic s_d_q;

  // NOTE: every flop is written with <= so all stages sample the pre-edge
  // value of their neighbour; a blocking '=' here would collapse the chain.
  always_ff @(posedge mclk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      s_q     <= 1'b1;
      s_d_q   <= 1'b1;
    end else begin
      sync1_q <= pwm_in;
      s_q     <= sync1_q;
      s_d_q   <= s_q;
    end
  end

  logic fall;
  logic rise;
  logic edge_seen;

  assign fall      = s_d_q & ~s_q;
  assign rise      = ~s_d_q & s_q;
  assign edge_seen = fall | rise;

  // ---------------------------------------------------------------------------
  // Measurement state
  // ---------------------------------------------------------------------------
  state_t           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [CNT_W-1:0] low_latch_q,  low_latch_d;
  logic [CNT_W-1:0] idle_q,       idle_d;
  logic [CNT_W-1:0] on_count_q,   on_count_d;
  logic [CNT_W-1:0] period_q,     period_d;
  logic             valid_q,      valid_d;
  logic             timeout_q,    timeout_d;
  logic             idle_level_q, idle_level_d;
  logic             overflow_q,   overflow_d;

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      low_latch_q  <= '0;
      idle_q       <= '0;
      on_count_q   <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      idle_level_q <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      low_latch_q  <= low_latch_d;
      idle_q       <= idle_d;
      on_count_q   <= on_count_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
      idle_level_q <= idle_level_d;
      overflow_q   <= overflow_d;
    end
  end

  logic             measuring;
  logic             tick;
  logic             cnt_at_max;
  logic [CNT_W-1:0] cnt_inc;
  logic             expire;

  assign measuring  = (state_q != ST_IDLE);
  assign tick       = measuring & equal;
  assign cnt_at_max = (cnt_q == CNT_MAX);
  // Saturating cnt + equal: the value latched on an edge includes the tick of
  // the edge cycle itself.
  assign cnt_inc    = (equal && !cnt_at_max) ? cnt_q + 1'b1 : cnt_q;
  // An edge in the expiry cycle takes priority over the timeout.
  assign expire     = tick & ~edge_seen & (idle_q == IDLE_LAST);

  // NOTE: every _d signal takes its hold value before any branch, so paths
  // that do not assign it cannot infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    low_latch_d  = low_latch_q;
    idle_d       = idle_q;
    on_count_d   = on_count_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    timeout_d    = 1'b0;
    idle_level_d = idle_level_q;
    overflow_d   = overflow_q | (tick & cnt_at_max);

    if (measuring) begin
      cnt_d = cnt_inc;
    end

    if (edge_seen) begin
      idle_d = '0;
    end else if (tick) begin
      idle_d = idle_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // First fall after idle only arms the measurement.
        if (fall) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end
      end
      ST_LOW: begin
        if (rise) begin
          low_latch_d = cnt_inc;
          state_d     = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          period_d   = cnt_inc;
          on_count_d = low_latch_q;
          valid_d    = 1'b1;
          cnt_d      = '0;
          state_d    = ST_LOW;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (expire) begin
      state_d      = ST_IDLE;
      timeout_d    = 1'b1;
      idle_level_d = s_q;
      cnt_d        = '0;
      idle_d       = '0;
    end
  end

  assign on_count     = on_count_q;
  assign period_count = period_q;
  assign valid        = valid_q;
  assign timeout      = timeout_q;
  assign idle_level   = idle_level_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
//
// Drives pwm_capture with directed PWM patterns followed by random segments.
// A reference model works on the stream of input samples: it finds edges,
// sums ticks between them and predicts every valid/timeout event together
// with the cycle it must appear in. Predictions go into a queue; a monitor on
// the falling clock edge pops and compares whenever the DUT pulses an output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 250;
  localparam int MAXV    = (1 << CNT_W) - 1;
  localparam int LAT     = 2;   // synchronizer delay from sample to detection

  logic             mclk = 1'b0;
  logic             rst;
  logic             equal;
  logic             pwm_in;
  logic [CNT_W-1:0] on_count;
  logic [CNT_W-1:0] period_count;
  logic             valid;
  logic             timeout;
  logic             idle_level;
  logic             overflow;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .mclk        (mclk),
    .rst         (rst),
    .equal       (equal),
    .pwm_in      (pwm_in),
    .on_count    (on_count),
    .period_count(period_count),
    .valid       (valid),
    .timeout     (timeout),
    .idle_level  (idle_level),
    .overflow    (overflow)
  );

  always #5 mclk = ~mclk;

  int edge_cnt = 0;
  always @(posedge mclk) edge_cnt <= edge_cnt + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef enum {EV_VALID, EV_TIMEOUT} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       at_edge;
    int       on_v;
    int       per_v;
    bit       lvl;
    bit       ovf;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  n_valid = 0;
  int  n_to    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  always @(negedge mclk) begin
    ev_t ev;
    if (valid === 1'b1 || timeout === 1'b1) begin
      check("valid_timeout_exclusive", {31'b0, valid & timeout}, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_event_queue_size", exp_q.size(), 1);
      end else begin
        ev = exp_q.pop_front();
        check("event_edge",   edge_cnt,     ev.at_edge);
        check("event_valid",  valid,        ev.kind == EV_VALID);
        check("event_timeout", timeout,     ev.kind == EV_TIMEOUT);
        check("on_count",     on_count,     ev.on_v);
        check("period_count", period_count, ev.per_v);
        check("overflow",     overflow,     ev.ovf);
        check("idle_level",   idle_level,   ev.lvl);
      end
      if (valid === 1'b1) n_valid++;
      if (timeout === 1'b1) n_to++;
    end else if (exp_q.size() > 0 && exp_q[0].at_edge <= edge_cnt) begin
      check("event_present", {31'b0, valid | timeout}, 1);
      void'(exp_q.pop_front());
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: operates on input samples, each paired with the tick the
  // DUT will see when that sample is acted on.
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_LOW, M_HIGH} m_state_t;
  m_state_t m_state = M_IDLE;
  bit prev_p   = 1'b1;
  int ticks    = 0;    // ticks since the last fall, unsaturated
  int on_ticks = 0;
  int idle_t   = 0;
  int last_on  = 0;
  int last_per = 0;
  bit m_level  = 1'b1;
  bit m_ovf    = 1'b0;

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic push(input ev_kind_t k, input int j);
    ev_t ev;
    ev.kind = k; ev.at_edge = j + LAT; ev.on_v = last_on; ev.per_v = last_per;
    ev.lvl = m_level; ev.ovf = m_ovf;
    exp_q.push_back(ev);
  endtask

  task automatic model(input bit p, input bit e, input bit r, input int j);
    bit fall, rise;
    if (r) begin
      m_state = M_IDLE; ticks = 0; on_ticks = 0; idle_t = 0;
      last_on = 0; last_per = 0; m_level = 1'b1; m_ovf = 1'b0;
      prev_p = 1'b1;   // the synchronizer restarts from 1
      for (int k = exp_q.size() - 1; k >= 0; k--)
        if (exp_q[k].at_edge >= j) exp_q.delete(k);
      return;
    end
    fall = prev_p && !p;
    rise = !prev_p && p;
    prev_p = p;
    if (m_state != M_IDLE && e) begin
      if (ticks >= MAXV) m_ovf = 1'b1;
      ticks++;
    end
    if (m_state == M_IDLE) begin
      if (fall) begin m_state = M_LOW; ticks = 0; idle_t = 0; end
    end else if (m_state == M_LOW && rise) begin
      on_ticks = ticks; m_state = M_HIGH; idle_t = 0;
    end else if (m_state == M_HIGH && fall) begin
      last_on = sat(on_ticks); last_per = sat(ticks);
      push(EV_VALID, j);
      ticks = 0; m_state = M_LOW; idle_t = 0;
    end else if (e) begin
      idle_t++;
      if (idle_t == TIMEOUT) begin
        m_level = p;
        push(EV_TIMEOUT, j);
        m_state = M_IDLE; ticks = 0; idle_t = 0;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  bit e_hist1 = 1'b0;
  bit e_hist2 = 1'b0;
  int phase   = 0;

  task automatic step(input bit p, input bit e, input bit r);
    int j;
    j = edge_cnt + 1;          // the edge that samples these inputs
    pwm_in  = p;
    rst     = r;
    equal   = e_hist2;         // tick paired with the sample from two steps ago
    e_hist2 = e_hist1;
    e_hist1 = e;
    model(p, e, r, j);
    @(posedge mclk);
    #1;
  endtask

  task automatic seg(input bit p, input int len, input int eq_every, input bit eq_rand);
    for (int i = 0; i < len; i++) begin
      bit e;
      if (eq_rand) e = ($urandom_range(0, 1) != 0);
      else         e = ((phase % eq_every) == 0);
      phase++;
      step(p, e, 1'b0);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_on_count",     on_count,     0);
    check("rst_period_count", period_count, 0);
    check("rst_valid",        valid,        0);
    check("rst_timeout",      timeout,      0);
    check("rst_idle_level",   idle_level,   1);
    check("rst_overflow",     overflow,     0);
  endtask

  initial begin
    int v0, t0;
    bit lvl;
    rst = 1'b1; pwm_in = 1'b1; equal = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    check_reset_outputs();

    // Low 10 / high 30 with a tick every cycle.
    v0 = n_valid;
    for (int i = 0; i < 4; i++) begin seg(0, 10, 1, 0); seg(1, 30, 1, 0); end
    seg(0, 5, 1, 0);
    check("s1_valid_count", n_valid - v0, 4);
    check("s1_on_count",     on_count,     10);
    check("s1_period_count", period_count, 40);

    // Tick every 4th cycle, low 40 / high 80.
    for (int i = 0; i < 3; i++) begin seg(0, 40, 4, 0); seg(1, 80, 4, 0); end
    seg(0, 5, 4, 0);
    check("s2_on_count",     on_count,     10);
    check("s2_period_count", period_count, 30);

    // Period longer than the counter range.
    for (int i = 0; i < 2; i++) begin seg(0, 100, 1, 0); seg(1, 200, 1, 0); end
    seg(0, 5, 1, 0);
    check("ovf_on_count",     on_count,     100);
    check("ovf_period_count", period_count, 255);
    check("ovf_flag",         overflow,     1);

    // Fall arriving exactly at the idle limit, then one tick past it.
    t0 = n_to;
    seg(1, TIMEOUT, 1, 0);
    seg(0, 10, 1, 0);
    check("edge_at_limit_no_timeout", n_to - t0, 0);
    seg(1, TIMEOUT + 1, 1, 0);
    seg(0, 10, 1, 0);
    check("limit_plus_one_timeout", n_to - t0, 1);
    check("timeout_high_level", idle_level, 1);
    seg(1, 10, 1, 0);
    seg(0, 5, 1, 0);

    // Input held low after a fall.
    t0 = n_to;
    seg(1, 10, 1, 0);
    seg(0, 600, 1, 0);
    check("hold_low_timeout",  n_to - t0,    1);
    check("hold_low_level",    idle_level,   0);
    check("hold_low_on_kept",  on_count,     5);
    check("hold_low_per_kept", period_count, 15);
    v0 = n_valid;
    seg(1, 10, 1, 0); seg(0, 10, 1, 0); seg(1, 10, 1, 0); seg(0, 5, 1, 0);
    check("after_idle_one_valid", n_valid - v0, 1);

    // Reset during the high phase.
    seg(1, 10, 1, 0);
    step(1'b1, 1'b1, 1'b1);
    check_reset_outputs();
    v0 = n_valid;
    seg(1, 5, 1, 0); seg(0, 10, 1, 0); seg(1, 30, 1, 0); seg(0, 5, 1, 0);
    check("after_rst_one_valid", n_valid - v0, 1);
    check("after_rst_on",        on_count,     10);
    check("after_rst_period",    period_count, 40);

    // Random segments.
    lvl = 1'b1;
    for (int i = 0; i < 60; i++) begin
      lvl = ~lvl;
      if ($urandom_range(0, 7) == 0) seg(lvl, $urandom_range(TIMEOUT + 5, TIMEOUT + 50), 1, 0);
      else                           seg(lvl, $urandom_range(1, 60), 1, ($urandom_range(0, 1) != 0));
    end

    seg(1, 20, 1, 0);
    check("all_events_seen", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
